// File: rtl/textmode_map_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : textmode_map_ctrl
//  Description : Write sequencer / arbiter for the 80x30 text-mode character
//                and colour maps. Passes single host writes through when idle
//                and runs clear-screen and scroll-up-one-row bulk commands.
//  Revision    : 1.0 - initial release
// ============================================================================
module textmode_map_ctrl #(
    parameter int COLS = 80,
    parameter int ROWS = 30,
    parameter int AW   = $clog2(COLS*ROWS)
) (
    input  logic          clk_25m,
    input  logic          rst,
    input  logic          host_valid_i,
    output logic          host_ready_o,
    input  logic          host_sel_i,
    input  logic [AW-1:0] host_addr_i,
    input  logic [7:0]    host_data_i,
    input  logic          cmd_valid_i,
    output logic          cmd_ready_o,
    input  logic [1:0]    cmd_op_i,
    input  logic [7:0]    cmd_char_i,
    input  logic [7:0]    cmd_color_i,
    output logic          busy_o,
    output logic          done_o,
    output logic [AW-1:0] ch_map_addr_o,
    output logic [7:0]    ch_map_data_o,
    output logic          ch_map_wen_o,
    output logic [AW-1:0] col_map_addr_o,
    output logic [7:0]    col_map_data_o,
    output logic          col_map_wen_o,
    input  logic [7:0]    ch_map_rdata_i,
    input  logic [7:0]    col_map_rdata_i
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_CLEAR    = 3'd1;
    localparam logic [2:0] S_SCR_RD   = 3'd2;
    localparam logic [2:0] S_SCR_WR   = 3'd3;
    localparam logic [2:0] S_SCR_FILL = 3'd4;
    localparam logic [2:0] S_DONE     = 3'd5;

    localparam logic [AW-1:0] c_ONE        = AW'(1);
    localparam logic [AW-1:0] c_COLS       = AW'(COLS);
    localparam logic [AW-1:0] c_LAST       = AW'(COLS*ROWS-1);
    localparam logic [AW-1:0] c_SRC_LAST   = AW'(COLS*(ROWS-1)-1);
    localparam logic [AW-1:0] c_FILL_FIRST = AW'(COLS*(ROWS-1));

    logic [2:0]    r_state;
    logic [AW-1:0] r_cnt;
    logic [7:0]    r_fill_char;
    logic [7:0]    r_fill_color;
    logic          w_cmd_accept;

    // cmd_ready_o already folds in reset, IDLE and host priority
    assign w_cmd_accept = cmd_valid_i & cmd_ready_o;

    // Sequencer: state, cell counter and latched fill values
    always_ff @(posedge clk_25m) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_fill_char  <= 8'h00;
            r_fill_color <= 8'h00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_cmd_accept) begin
                        r_fill_char  <= cmd_char_i;
                        r_fill_color <= cmd_color_i;
                        r_cnt        <= '0;
                        case (cmd_op_i)
                            2'b00:   r_state <= S_CLEAR;
                            2'b01:   r_state <= S_SCR_RD;
                            default: r_state <= S_DONE;
                        endcase
                    end
                end
                S_CLEAR, S_SCR_FILL: begin
                    if (r_cnt == c_LAST) begin
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + c_ONE;
                    end
                end
                S_SCR_RD: begin
                    r_state <= S_SCR_WR;
                end
                S_SCR_WR: begin
                    // Source row stops at the last row; the last row is then filled
                    if (r_cnt == c_SRC_LAST) begin
                        r_cnt   <= c_FILL_FIRST;
                        r_state <= S_SCR_FILL;
                    end else begin
                        r_cnt   <= r_cnt + c_ONE;
                        r_state <= S_SCR_RD;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Map port and handshake decode; everything is quiet while rst is high
    always_comb begin
        host_ready_o   = 1'b0;
        cmd_ready_o    = 1'b0;
        busy_o         = 1'b0;
        done_o         = 1'b0;
        ch_map_addr_o  = '0;
        ch_map_data_o  = 8'h00;
        ch_map_wen_o   = 1'b0;
        col_map_addr_o = '0;
        col_map_data_o = 8'h00;
        col_map_wen_o  = 1'b0;
        if (!rst) begin
            case (r_state)
                S_IDLE: begin
                    host_ready_o = 1'b1;
                    cmd_ready_o  = !host_valid_i;
                    if (host_valid_i) begin
                        ch_map_addr_o  = host_addr_i;
                        col_map_addr_o = host_addr_i;
                        ch_map_data_o  = host_data_i;
                        col_map_data_o = host_data_i;
                        ch_map_wen_o   = !host_sel_i;
                        col_map_wen_o  = host_sel_i;
                    end
                end
                S_CLEAR, S_SCR_FILL: begin
                    busy_o         = 1'b1;
                    ch_map_addr_o  = r_cnt;
                    col_map_addr_o = r_cnt;
                    ch_map_data_o  = r_fill_char;
                    col_map_data_o = r_fill_color;
                    ch_map_wen_o   = 1'b1;
                    col_map_wen_o  = 1'b1;
                end
                S_SCR_RD: begin
                    busy_o         = 1'b1;
                    ch_map_addr_o  = r_cnt + c_COLS;
                    col_map_addr_o = r_cnt + c_COLS;
                end
                S_SCR_WR: begin
                    busy_o         = 1'b1;
                    ch_map_addr_o  = r_cnt;
                    col_map_addr_o = r_cnt;
                    ch_map_data_o  = ch_map_rdata_i;
                    col_map_data_o = col_map_rdata_i;
                    ch_map_wen_o   = 1'b1;
                    col_map_wen_o  = 1'b1;
                end
                S_DONE: begin
                    busy_o = 1'b1;
                    done_o = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_textmode_map_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_textmode_map_ctrl
//  Description : Self-checking bench for textmode_map_ctrl with map RAMs,
//                a cycle-numbered reference model and randomized traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_textmode_map_ctrl;

    localparam int COLS     = 80;
    localparam int ROWS     = 30;
    localparam int AW       = 12;
    localparam int CELLS    = COLS*ROWS;
    localparam int SRC      = COLS*(ROWS-1);
    localparam int N_CLEAR  = CELLS + 1;
    localparam int N_SCROLL = 2*SRC + COLS + 1;

    logic          clk_25m = 1'b0;
    logic          rst = 1'b1;
    logic          host_valid_i = 1'b0;
    logic          host_ready_o;
    logic          host_sel_i = 1'b0;
    logic [AW-1:0] host_addr_i = '0;
    logic [7:0]    host_data_i = 8'h00;
    logic          cmd_valid_i = 1'b0;
    logic          cmd_ready_o;
    logic [1:0]    cmd_op_i = 2'b00;
    logic [7:0]    cmd_char_i = 8'h00;
    logic [7:0]    cmd_color_i = 8'h00;
    logic          busy_o;
    logic          done_o;
    logic [AW-1:0] ch_map_addr_o;
    logic [7:0]    ch_map_data_o;
    logic          ch_map_wen_o;
    logic [AW-1:0] col_map_addr_o;
    logic [7:0]    col_map_data_o;
    logic          col_map_wen_o;
    logic [7:0]    ch_map_rdata_i;
    logic [7:0]    col_map_rdata_i;

    int checks = 0;
    int errors = 0;

    textmode_map_ctrl #(.COLS(COLS), .ROWS(ROWS), .AW(AW)) dut (
        .clk_25m(clk_25m), .rst(rst),
        .host_valid_i(host_valid_i), .host_ready_o(host_ready_o),
        .host_sel_i(host_sel_i), .host_addr_i(host_addr_i), .host_data_i(host_data_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_op_i(cmd_op_i),
        .cmd_char_i(cmd_char_i), .cmd_color_i(cmd_color_i),
        .busy_o(busy_o), .done_o(done_o),
        .ch_map_addr_o(ch_map_addr_o), .ch_map_data_o(ch_map_data_o), .ch_map_wen_o(ch_map_wen_o),
        .col_map_addr_o(col_map_addr_o), .col_map_data_o(col_map_data_o), .col_map_wen_o(col_map_wen_o),
        .ch_map_rdata_i(ch_map_rdata_i), .col_map_rdata_i(col_map_rdata_i)
    );

    always #20 clk_25m = ~clk_25m;

    // Map RAMs driven by the DUT's port A, one-cycle read latency
    logic [7:0] mem_ch  [0:4095];
    logic [7:0] mem_col [0:4095];
    always @(posedge clk_25m) begin
        if (ch_map_wen_o)  mem_ch[ch_map_addr_o]   <= ch_map_data_o;
        if (col_map_wen_o) mem_col[col_map_addr_o] <= col_map_data_o;
        ch_map_rdata_i  <= mem_ch[ch_map_addr_o];
        col_map_rdata_i <= mem_col[col_map_addr_o];
    end

    // Reference screen contents and command progress, indexed by engine cycle
    logic [7:0] ref_ch  [0:CELLS-1];
    logic [7:0] ref_col [0:CELLS-1];
    logic       m_busy;
    logic [1:0] m_op;
    int         m_n;
    logic [7:0] m_char, m_col;

    function automatic int last_n(input logic [1:0] op);
        if (op == 2'b00) return N_CLEAR;
        if (op == 2'b01) return N_SCROLL;
        return 1;
    endfunction

    // Which cell (if any) engine cycle n of command op writes, and with what
    task automatic exp_write(input logic [1:0] op, input int n, input logic [7:0] fc, input logic [7:0] fk,
                             output logic v, output int a, output logic [7:0] cd, output logic [7:0] kd);
        v = 1'b0; a = 0; cd = 8'h00; kd = 8'h00;
        if (op == 2'b00 && n >= 1 && n <= CELLS) begin
            v = 1'b1; a = n - 1; cd = fc; kd = fk;
        end else if (op == 2'b01) begin
            if (n <= 2*SRC) begin
                if (n % 2 == 0) begin
                    v = 1'b1; a = n/2 - 1; cd = ref_ch[a + COLS]; kd = ref_col[a + COLS];
                end
            end else if (n <= 2*SRC + COLS) begin
                v = 1'b1; a = SRC + (n - 2*SRC - 1); cd = fc; kd = fk;
            end
        end
    endtask

    always @(posedge clk_25m) begin : p_model
        logic v; int a; logic [7:0] cd, kd;
        if (rst) begin
            m_busy <= 1'b0;
        end else if (m_busy !== 1'b1) begin
            m_busy <= 1'b0;
            if (host_valid_i) begin
                if (host_sel_i) ref_col[host_addr_i] <= host_data_i;
                else            ref_ch[host_addr_i]  <= host_data_i;
            end else if (cmd_valid_i) begin
                m_busy <= 1'b1; m_op <= cmd_op_i; m_n <= 1;
                m_char <= cmd_char_i; m_col <= cmd_color_i;
            end
        end else begin
            exp_write(m_op, m_n, m_char, m_col, v, a, cd, kd);
            if (v) begin
                ref_ch[a]  <= cd;
                ref_col[a] <= kd;
            end
            if (m_n == last_n(m_op)) m_busy <= 1'b0;
            else                     m_n <= m_n + 1;
        end
    end

    // Every-cycle comparison of all DUT outputs against the model
    always @(negedge clk_25m) begin : p_cmp
        logic e_hr, e_cr, e_busy, e_done, e_chw, e_colw;
        logic [AW-1:0] e_addr;
        logic [7:0] e_chd, e_cold;
        logic chk_addr, chk_chd, chk_cold, ok, v;
        int a; logic [7:0] cd, kd;
        e_hr = 0; e_cr = 0; e_busy = 0; e_done = 0; e_chw = 0; e_colw = 0;
        e_addr = '0; e_chd = 8'h00; e_cold = 8'h00;
        chk_addr = 1; chk_chd = 1; chk_cold = 1;
        if (rst) begin
        end else if (m_busy !== 1'b1) begin
            e_hr = 1; e_cr = !host_valid_i;
            if (host_valid_i) begin
                e_addr = host_addr_i;
                if (host_sel_i) begin e_colw = 1; e_cold = host_data_i; chk_chd = 0; end
                else            begin e_chw = 1;  e_chd = host_data_i;  chk_cold = 0; end
            end
        end else begin
            e_busy = 1;
            e_done = (m_n == last_n(m_op));
            exp_write(m_op, m_n, m_char, m_col, v, a, cd, kd);
            if (v) begin
                e_chw = 1; e_colw = 1; e_addr = AW'(a); e_chd = cd; e_cold = kd;
            end else if (m_op == 2'b01 && (m_n % 2) == 1 && m_n <= 2*SRC) begin
                e_addr = AW'((m_n - 1)/2 + COLS); chk_chd = 0; chk_cold = 0;
            end else begin
                chk_addr = 0; chk_chd = 0; chk_cold = 0;
            end
        end
        ok = (host_ready_o === e_hr) && (cmd_ready_o === e_cr) && (busy_o === e_busy) &&
             (done_o === e_done) && (ch_map_wen_o === e_chw) && (col_map_wen_o === e_colw);
        if (chk_addr) ok = ok && (ch_map_addr_o === e_addr) && (col_map_addr_o === e_addr);
        if (chk_chd)  ok = ok && (ch_map_data_o === e_chd);
        if (chk_cold) ok = ok && (col_map_data_o === e_cold);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL cycle_cmp t=%0t actual hr/cr/busy/done/chw/colw=%b%b%b%b%b%b addr=%h/%h data=%h/%h required %b%b%b%b%b%b addr=%h data=%h/%h",
                     $time, host_ready_o, cmd_ready_o, busy_o, done_o, ch_map_wen_o, col_map_wen_o,
                     ch_map_addr_o, col_map_addr_o, ch_map_data_o, col_map_data_o,
                     e_hr, e_cr, e_busy, e_done, e_chw, e_colw, e_addr, e_chd, e_cold);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk_25m);
        #1;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(negedge clk_25m);
            n++;
        end while (done_o !== 1'b1 && n < 6000);
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [7:0] fc, input logic [7:0] fk, output int n);
        cmd_valid_i = 1; cmd_op_i = op; cmd_char_i = fc; cmd_color_i = fk;
        step();
        cmd_valid_i = 0;
        wait_done(n);
        step();
    endtask

    initial begin
        #(40*60000);
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int n, bad;
        logic [7:0] fc, fk;

        // Reset
        repeat (3) step();
        @(negedge clk_25m);
        check("rst_host_ready", host_ready_o, 0);
        check("rst_busy", busy_o, 0);
        step();
        rst = 0;
        @(negedge clk_25m);
        check("idle_host_ready", host_ready_o, 1);
        check("idle_done", done_o, 0);
        step();

        // Preload cell k with char k[7:0], colour ~k[7:0]
        for (int k = 0; k < CELLS; k++) begin
            host_valid_i = 1; host_sel_i = 0; host_addr_i = AW'(k); host_data_i = 8'(k);
            step();
            host_sel_i = 1; host_data_i = ~8'(k);
            step();
        end
        host_valid_i = 0;

        // Scroll up with fill 0x2E / 0x1E
        run_cmd(2'b01, 8'h2E, 8'h1E, n);
        check("scroll_done_cycle", n, 4721);
        bad = 0;
        for (int a = 0; a < CELLS; a++) begin
            fc = (a < SRC) ? 8'(a + COLS) : 8'h2E;
            fk = (a < SRC) ? ~8'(a + COLS) : 8'h1E;
            if (mem_ch[a] !== fc || mem_col[a] !== fk) bad++;
        end
        check("scroll_contents_bad_cells", bad, 0);
        check("scroll_cell0_ch", mem_ch[0], 8'h50);
        check("scroll_cell2399_col", mem_col[2399], 8'h1E);

        // Single host write to the colour map
        host_valid_i = 1; host_sel_i = 1; host_addr_i = 12'h123; host_data_i = 8'hA5;
        @(negedge clk_25m);
        check("hw_col_wen", col_map_wen_o, 1);
        check("hw_col_addr", col_map_addr_o, 12'h123);
        check("hw_col_data", col_map_data_o, 8'hA5);
        check("hw_ch_wen", ch_map_wen_o, 0);
        step();
        host_valid_i = 0;

        // Clear screen
        run_cmd(2'b00, 8'h20, 8'h0F, n);
        check("clear_done_cycle", n, 2401);
        bad = 0;
        for (int a = 0; a < CELLS; a++)
            if (mem_ch[a] !== 8'h20 || mem_col[a] !== 8'h0F) bad++;
        check("clear_contents_bad_cells", bad, 0);

        // Contention: host write and command in the same IDLE cycle
        host_valid_i = 1; host_sel_i = 0; host_addr_i = 12'd5; host_data_i = 8'h77;
        cmd_valid_i = 1; cmd_op_i = 2'b00; cmd_char_i = 8'h20; cmd_color_i = 8'h0F;
        @(negedge clk_25m);
        check("cont_cmd_ready", cmd_ready_o, 0);
        check("cont_host_wen", ch_map_wen_o, 1);
        step();
        host_valid_i = 0;
        @(negedge clk_25m);
        check("cont_cmd_ready_next", cmd_ready_o, 1);
        step();
        cmd_valid_i = 0;
        host_valid_i = 1; host_sel_i = 1; host_addr_i = 12'd7; host_data_i = 8'h3C;
        wait_done(n);
        check("cont_done_cycle", n, 2401);
        check("cont_host_ready_busy", host_ready_o, 0);
        step();
        @(negedge clk_25m);
        check("cont_held_write_wen", col_map_wen_o, 1);
        check("cont_held_write_addr", col_map_addr_o, 12'd7);
        step();
        host_valid_i = 0;
        check("cont_held_write_mem", mem_col[7], 8'h3C);

        // Reset in engine cycle 100 of a clear
        cmd_valid_i = 1; cmd_op_i = 2'b00; cmd_char_i = 8'h55; cmd_color_i = 8'hAA;
        step();
        cmd_valid_i = 0;
        repeat (99) step();
        rst = 1;
        step();
        rst = 0;
        @(negedge clk_25m);
        check("rstmid_busy", busy_o, 0);
        check("rstmid_host_ready", host_ready_o, 1);
        step();
        check("rstmid_ch98", mem_ch[98], 8'h55);
        check("rstmid_col98", mem_col[98], 8'hAA);
        check("rstmid_ch99", mem_ch[99], 8'h20);
        check("rstmid_col99", mem_col[99], 8'h0F);

        // Reserved op: one DONE cycle, no writes
        cmd_valid_i = 1; cmd_op_i = 2'b11;
        step();
        cmd_valid_i = 0;
        @(negedge clk_25m);
        check("rsv_busy", busy_o, 1);
        check("rsv_done", done_o, 1);
        check("rsv_wen", {ch_map_wen_o, col_map_wen_o}, 0);
        step();
        @(negedge clk_25m);
        check("rsv_idle", busy_o, 0);
        step();

        // Randomized host traffic, short commands and occasional resets
        for (int i = 0; i < 800; i++) begin
            host_valid_i = ($urandom_range(0, 2) == 0);
            host_sel_i   = 1'($urandom_range(0, 1));
            host_addr_i  = AW'($urandom_range(0, CELLS-1));
            host_data_i  = 8'($urandom);
            cmd_valid_i  = ($urandom_range(0, 5) == 0);
            cmd_op_i     = 2'($urandom_range(2, 3));
            cmd_char_i   = 8'($urandom);
            cmd_color_i  = 8'($urandom);
            rst          = ($urandom_range(0, 149) == 0);
            step();
        end
        host_valid_i = 0; cmd_valid_i = 0; rst = 0;
        repeat (3) step();

        bad = 0;
        for (int a = 0; a < CELLS; a++)
            if (mem_ch[a] !== ref_ch[a] || mem_col[a] !== ref_col[a]) bad++;
        check("final_mem_vs_model", bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
